// File: rtl/operand_fetch_stage_if.sv
// rtl/operand_fetch_stage_if.sv - decoded-instruction, ALU-side and writeback bundle for the operand fetch stage
package operand_fetch_pkg;
    typedef logic [31:0] instruction_t;
endpackage

interface operand_fetch_stage_if #(
    parameter int REGISTER_WIDTH = 32,
    parameter int REGISTER_COUNT = 32
);
    import operand_fetch_pkg::*;
    localparam int IDX_W = $clog2(REGISTER_COUNT);

    logic                      in_valid;
    logic                      in_ready;
    instruction_t              in_instruction;
    logic [IDX_W-1:0]          in_rs1;
    logic [IDX_W-1:0]          in_rs2;
    logic [IDX_W-1:0]          in_rd;
    logic [REGISTER_WIDTH-1:0] in_imm;
    logic                      in_use_imm;

    logic                      out_valid;
    logic                      out_ready;
    instruction_t              out_instruction;
    logic [IDX_W-1:0]          out_rd;
    logic [REGISTER_WIDTH-1:0] input1;
    logic [REGISTER_WIDTH-1:0] input2;

    logic                      wb_valid;
    logic [IDX_W-1:0]          wb_rd;
    logic [REGISTER_WIDTH-1:0] wb_data;

    modport master (
        output in_valid, in_instruction, in_rs1, in_rs2, in_rd, in_imm, in_use_imm,
        input  in_ready,
        input  out_valid, out_instruction, out_rd, input1, input2,
        output out_ready,
        output wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  in_valid, in_instruction, in_rs1, in_rs2, in_rd, in_imm, in_use_imm,
        output in_ready,
        output out_valid, out_instruction, out_rd, input1, input2,
        input  out_ready,
        input  wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// rtl/operand_fetch_stage.sv - register file, busy scoreboard and registered ALU operand stage
module operand_fetch_stage
    import operand_fetch_pkg::*;
#(
    parameter int REGISTER_WIDTH = 32,
    parameter int REGISTER_COUNT = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    operand_fetch_stage_if.slave bus
);
    localparam int IDX_W = $clog2(REGISTER_COUNT);

    logic [REGISTER_WIDTH-1:0] regs [REGISTER_COUNT];
    logic [REGISTER_COUNT-1:0] busy;
    logic [REGISTER_COUNT-1:0] busy_next;
    logic                      wb_live;

    logic                      wb_en;
    logic [REGISTER_WIDTH-1:0] rs1_val;
    logic [REGISTER_WIDTH-1:0] rs2_val;
    logic                      rs1_busy;
    logic                      rs2_busy;
    logic                      rd_busy;
    logic                      hazard;
    logic                      accept;

    // Writeback is honoured only once the stage has seen one edge out of reset; x0 commits are dropped.
    always_comb begin
        wb_en = bus.wb_valid && wb_live && (bus.wb_rd != '0);
    end

    // Register reads with same-cycle writeback bypass; x0 always reads zero.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (bus.in_rs1 != '0) begin
            rs1_val = (wb_en && bus.wb_rd == bus.in_rs1) ? bus.wb_data : regs[bus.in_rs1];
        end
        if (bus.in_rs2 != '0) begin
            rs2_val = (wb_en && bus.wb_rd == bus.in_rs2) ? bus.wb_data : regs[bus.in_rs2];
        end
    end

    // Hazard detection: a busy register counts as free when its writeback lands this cycle.
    always_comb begin
        rs1_busy = busy[bus.in_rs1] && !(wb_en && bus.wb_rd == bus.in_rs1);
        rs2_busy = busy[bus.in_rs2] && !(wb_en && bus.wb_rd == bus.in_rs2);
        rd_busy  = busy[bus.in_rd]  && !(wb_en && bus.wb_rd == bus.in_rd);
        hazard   = rs1_busy || (!bus.in_use_imm && rs2_busy) || ((bus.in_rd != '0) && rd_busy);
        bus.in_ready = (!bus.out_valid || bus.out_ready) && !hazard;
        accept   = bus.in_valid && bus.in_ready;
    end

    // Scoreboard update: clear on writeback, then set on accept so a same-index set wins.
    always_comb begin
        busy_next = busy;
        if (wb_en) begin
            busy_next[bus.wb_rd] = 1'b0;
        end
        if (accept && bus.in_rd != '0) begin
            busy_next[bus.in_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Architectural state: register file, busy bits and the writeback-enable flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGISTER_COUNT; i++) begin
                regs[i] <= '0;
            end
            busy    <= '0;
            wb_live <= 1'b0;
        end else begin
            wb_live <= 1'b1;
            busy    <= busy_next;
            if (wb_en) begin
                regs[bus.wb_rd] <= bus.wb_data;
            end
        end
    end

    // Output register: load on accept, drop valid when drained, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid       <= 1'b0;
            bus.input1          <= '0;
            bus.input2          <= '0;
            bus.out_rd          <= '0;
            bus.out_instruction <= instruction_t'(0);
        end else if (accept) begin
            bus.out_valid       <= 1'b1;
            bus.input1          <= rs1_val;
            bus.input2          <= bus.in_use_imm ? bus.in_imm : rs2_val;
            bus.out_rd          <= bus.in_rd;
            bus.out_instruction <= bus.in_instruction;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
